alu_regfile: RTL and testbench
==============================

# alu_regfile

Operand register file and status-flag register that sits directly upstream of the 16-bit ALU, feeding its `A` and `B` inputs and capturing its `Result` and flag outputs on write-back. It provides two combinational read ports, one synchronous write port with same-cycle write-to-read bypass, and a hard-wired zero register R0. A separate registered flag word holds the ALU's `Cout`, `Zero`, `Negative` and `Less` outputs for later conditional logic.

## Interface

- `DATA_WIDTH`, 16, word width; matches the ALU operand and result width.
- `NUM_REGS`, 8, number of registers; address width is `$clog2(NUM_REGS)`, which is 3 at the default.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high; takes effect on the rising edge.
- `rd_addr_a`  input  3  read port A address; drives ALU `A`.
- `rd_addr_b`  input  3  read port B address; drives ALU `B`.
- `rd_data_a`  output  16  combinational read data, port A.
- `rd_data_b`  output  16  combinational read data, port B.
- `wr_en`  input  1  write enable for the write port.
- `wr_addr`  input  3  write address.
- `wr_data`  input  16  write data; connected to ALU `Result`.
- `flag_we`  input  1  load enable for the flag register.
- `flags_in`  input  4  `{Cout, Zero, Negative, Less}` from the ALU.
- `flags_out`  output  4  registered flags, same bit order as `flags_in`.
- `wr_count`  output  16  count of accepted, non-discarded register writes since reset; wraps.

## Operation

- Storage is `NUM_REGS` words of `DATA_WIDTH` bits.
- R0 is hard-wired zero:
  - Reads of address 0 always return 16'h0000.
  - Writes to address 0 are discarded.
  - Discarded writes do not increment `wr_count`.
- Write on the rising edge when `wr_en`=1, `reset`=0 and `wr_addr`≠0: `reg[wr_addr]` ← `wr_data`, and `wr_count` ← `wr_count`+1 (mod 2^16, 16'hFFFF wraps to 16'h0000).
- Read port X (A or B), combinational:
  - If `rd_addr_x`=0: output 0.
  - Else if `wr_en`=1, `wr_addr`=`rd_addr_x` and `reset`=0: output `wr_data` (bypass).
  - Else: output `reg[rd_addr_x]`.
- Both ports may read the same address. Both ports may bypass in the same cycle.
- Flag register: on the rising edge with `flag_we`=1 and `reset`=0, `flags_out` ← `flags_in`. Otherwise it holds.
- The flag register is independent of `wr_en`; flags can update without a register write and vice versa.
- Reset has priority over `wr_en` and `flag_we` in the same cycle. While `reset`=1 the bypass is disabled, so reads return array contents.

## Timing

- Reset values, applied one edge after `reset` is sampled high:
  - All registers 0.
  - `flags_out` = 4'b0000.
  - `wr_count` = 0.
- Reset asserted mid-sequence: a write presented in the reset cycle is lost. Registers read 0 from the cycle after the reset edge.
- Write latency: data written at edge N is visible via the array from the cycle after edge N. During the write cycle itself it is visible via the bypass.
- Read latency: zero cycles; a purely combinational path from `rd_addr_*` and the write port to `rd_data_*`.
- Flag latency: `flags_out` reflects `flags_in` one edge after `flag_we`.
- No handshake; the write port accepts every cycle.
- Back-to-back writes to the same address: the last write wins. The bypass always shows the current cycle's `wr_data`.
- Out-of-range addresses (only possible when `NUM_REGS` is not a power of two): reads return 0 and writes are discarded.

## Test plan

- Reset: write 16'h1234 to R3, then assert `reset` for 1 cycle -> `rd_data_a`(R3)=0, `flags_out`=0, `wr_count`=0.
- Write/read: write R1=16'h00FF, then R2=16'hFF00; next cycle read A=R1, B=R2 -> 16'h00FF / 16'hFF00, `wr_count`=2.
- Bypass: in one cycle `wr_en`=1, `wr_addr`=5, `wr_data`=16'hBEEF, both read ports at 5 -> both outputs 16'hBEEF that cycle and in the following cycle.
- R0: write 16'hFFFF to R0 -> reads of R0 return 0, including same-cycle bypass; `wr_count` unchanged.
- Flags: `flag_we`=1 with `flags_in`=4'b1010, then `flag_we`=0 with `flags_in`=4'b0101 -> `flags_out` = 4'b1010 after both edges. Reset and `flag_we` in the same cycle -> 4'b0000.
- Counter wrap: force 65535 accepted writes, then one more -> `wr_count` goes 16'hFFFF -> 16'h0000.

Source files
------------

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : alu_regfile
//  Purpose  : Operand register file and status-flag register for the 16-bit
//             ALU. Two combinational read ports (ALU A/B), one synchronous
//             write port with same-cycle write-to-read bypass, hard-wired
//             zero register R0, a registered flag word and a write counter.
//  Ports    : clk, reset              - clock, synchronous active-high reset
//             rd_addr_a / rd_data_a   - read port A (feeds ALU A)
//             rd_addr_b / rd_data_b   - read port B (feeds ALU B)
//             wr_en, wr_addr, wr_data - write port (wr_data = ALU Result)
//             flag_we, flags_in       - flag load, {Cout, Zero, Neg, Less}
//             flags_out               - registered flags, same bit order
//             wr_count                - accepted register writes, wraps
//  Revision : 1.0 - initial release
// ============================================================================
module alu_regfile #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REGS   = 8,
  localparam int c_ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [c_ADDR_W-1:0]   rd_addr_a,
  input  logic [c_ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [c_ADDR_W-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flag_we,
  input  logic [3:0]            flags_in,
  output logic [3:0]            flags_out,
  output logic [15:0]           wr_count
);

  // One extra bit so the range test also works when NUM_REGS is a power of two.
  localparam logic [c_ADDR_W:0] c_NUM_REGS = (c_ADDR_W + 1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [3:0]            flags_q, flags_d;
  logic [15:0]           wr_count_q, wr_count_d;

  logic                  w_wr_accept;
  logic [c_ADDR_W-1:0]   w_rd_addr [2];
  logic [DATA_WIDTH-1:0] w_rd_data [2];

  // A write counts only if it targets a real, non-zero register outside reset.
  // R0 is therefore never written and stays at its reset value of zero.
  assign w_wr_accept = wr_en && !reset && (wr_addr != '0)
                       && ({1'b0, wr_addr} < c_NUM_REGS);

  // --------------------------------------------------------------------------
  // Read ports: R0 / out-of-range -> 0, then bypass, then array contents.
  // The bypass is qualified by reset so reads during reset see the array.
  // --------------------------------------------------------------------------
  assign w_rd_addr[0] = rd_addr_a;
  assign w_rd_addr[1] = rd_addr_b;

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    always_comb begin
      w_rd_data[p] = '0;
      if ((w_rd_addr[p] != '0) && ({1'b0, w_rd_addr[p]} < c_NUM_REGS)) begin
        if (wr_en && !reset && (wr_addr == w_rd_addr[p])) begin
          w_rd_data[p] = wr_data;
        end else begin
          w_rd_data[p] = mem_q[w_rd_addr[p]];
        end
      end
    end
  end

  assign rd_data_a = w_rd_data[0];
  assign rd_data_b = w_rd_data[1];

  // --------------------------------------------------------------------------
  // Storage array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_accept) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Flag register and write counter
  // --------------------------------------------------------------------------
  always_comb begin
    flags_d    = flags_q;
    wr_count_d = wr_count_q;
    if (flag_we) begin
      flags_d = flags_in;
    end
    if (w_wr_accept) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= 4'b0000;
      wr_count_q <= 16'd0;
    end else begin
      flags_q    <= flags_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign flags_out = flags_q;
  assign wr_count  = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_regfile
//  Purpose  : Self-checking bench for alu_regfile. Expected values are pushed
//             to a scoreboard queue as stimulus is driven and popped when the
//             outputs are sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_regfile;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wr_data;
  logic          wr_en, flag_we;
  logic [3:0]    flags_in, flags_out;
  logic [15:0]   wr_count;

  int            checks = 0;
  int            errors = 0;
  logic [15:0]   exp_q [$];
  logic [15:0]   exp_v;
  logic [15:0]   model_cnt;

  always #5 clk = ~clk;

  alu_regfile #(.DATA_WIDTH(16), .NUM_REGS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flag_we   (flag_we),
    .flags_in  (flags_in),
    .flags_out (flags_out),
    .wr_count  (wr_count)
  );

  task automatic idle();
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    flag_we  = 1'b0;
    flags_in = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_cnt = 16'd0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    // After the power-on reset everything reads zero.
    rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL por_rd_a: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if ({12'h0, flags_out} !== exp_v) begin errors++; $display("FAIL por_flags: got %b expected %b", flags_out, exp_v[3:0]); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL por_count: got %h expected %h", wr_count, exp_v); end

    // Write R3 and load flags, then reset with another write pending.
    step();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
    flag_we = 1'b1; flags_in = 4'b1111;
    model_cnt++;
    step();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h5555;
    flag_we = 1'b1; flags_in = 4'b0110;
    // Bypass is off during reset: the array value shows through.
    exp_q.push_back(16'h1234); exp_q.push_back(16'h000F); exp_q.push_back(model_cnt);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL rst_cycle_rd_a: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if ({12'h0, flags_out} !== exp_v) begin errors++; $display("FAIL pre_rst_flags: got %b expected %b", flags_out, exp_v[3:0]); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL pre_rst_count: got %h expected %h", wr_count, exp_v); end
    step();
    idle();
    model_cnt = 16'd0;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000); exp_q.push_back(model_cnt);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL rst_rd_a: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if ({12'h0, flags_out} !== exp_v) begin errors++; $display("FAIL rst_flags: got %b expected %b", flags_out, exp_v[3:0]); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL rst_count: got %h expected %h", wr_count, exp_v); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_write_read();
    step();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h00FF; model_cnt++;
    step();
    wr_addr = 3'd2; wr_data = 16'hFF00; model_cnt++;
    step();
    idle();
    rd_addr_a = 3'd1; rd_addr_b = 3'd2;
    exp_q.push_back(16'h00FF); exp_q.push_back(16'hFF00); exp_q.push_back(model_cnt);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL wr_rd_a: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("FAIL wr_rd_b: got %h expected %h", rd_data_b, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL wr_count2: got %h expected %h", wr_count, exp_v); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_bypass();
    step();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; model_cnt++;
    rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL byp_a: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("FAIL byp_b: got %h expected %h", rd_data_b, exp_v); end
    step();
    idle();
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'hBEEF); exp_q.push_back(model_cnt);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL byp_after_a: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("FAIL byp_after_b: got %h expected %h", rd_data_b, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL byp_count: got %h expected %h", wr_count, exp_v); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_r0();
    step();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL r0_byp_a: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("FAIL r0_byp_b: got %h expected %h", rd_data_b, exp_v); end
    step();
    idle();
    rd_addr_b = 3'd5;
    exp_q.push_back(16'h0000); exp_q.push_back(16'hBEEF); exp_q.push_back(model_cnt);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL r0_read: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("FAIL r0_r5: got %h expected %h", rd_data_b, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL r0_count: got %h expected %h", wr_count, exp_v); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_flags();
    step();
    flag_we = 1'b1; flags_in = 4'b1010;
    step();
    flag_we = 1'b0; flags_in = 4'b0101;
    exp_q.push_back(16'h000A);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({12'h0, flags_out} !== exp_v) begin errors++; $display("FAIL flag_load: got %b expected %b", flags_out, exp_v[3:0]); end
    step();
    exp_q.push_back(16'h000A); exp_q.push_back(model_cnt);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({12'h0, flags_out} !== exp_v) begin errors++; $display("FAIL flag_hold: got %b expected %b", flags_out, exp_v[3:0]); end
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL flag_no_wr: got %h expected %h", wr_count, exp_v); end
    // Reset wins over a simultaneous flag load.
    reset = 1'b1; flag_we = 1'b1; flags_in = 4'b1111;
    step();
    idle();
    model_cnt = 16'd0;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({12'h0, flags_out} !== exp_v) begin errors++; $display("FAIL flag_rst_prio: got %b expected %b", flags_out, exp_v[3:0]); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    step();
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hAAAA; model_cnt++;
    step();
    wr_data = 16'h5555; model_cnt++;
    rd_addr_a = 3'd4; rd_addr_b = 3'd2;
    // Array holds AAAA, bypass shows the current cycle's data; R2 was reset.
    exp_q.push_back(16'h5555); exp_q.push_back(16'h0000);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL b2b_byp: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("FAIL b2b_r2: got %h expected %h", rd_data_b, exp_v); end
    step();
    wr_addr = 3'd1; wr_data = 16'h1111; model_cnt++;
    rd_addr_a = 3'd1; rd_addr_b = 3'd4;
    exp_q.push_back(16'h1111); exp_q.push_back(16'h5555);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL b2b_r1_byp: got %h expected %h", rd_data_a, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_b !== exp_v) begin errors++; $display("FAIL b2b_last_wins: got %h expected %h", rd_data_b, exp_v); end
    step();
    idle();
    exp_q.push_back(model_cnt);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL b2b_count: got %h expected %h", wr_count, exp_v); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_counter_wrap();
    logic [AW-1:0] last_addr;
    logic [15:0]   last_data;
    step();
    do_reset();
    last_addr = '0;
    last_data = '0;
    for (int i = 0; i < 65535; i++) begin
      wr_en     = 1'b1;
      last_addr = AW'((i % 7) + 1);
      last_data = 16'(i);
      wr_addr   = last_addr;
      wr_data   = last_data;
      model_cnt = model_cnt + 16'd1;
      step();
    end
    idle();
    rd_addr_a = last_addr;
    exp_q.push_back(model_cnt); exp_q.push_back(last_data);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL wrap_ffff: got %h expected %h", wr_count, exp_v); end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data_a !== exp_v) begin errors++; $display("FAIL wrap_last_data: got %h expected %h", rd_data_a, exp_v); end
    step();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h0042;
    model_cnt = model_cnt + 16'd1;
    step();
    idle();
    exp_q.push_back(model_cnt);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (wr_count !== exp_v) begin errors++; $display("FAIL wrap_zero: got %h expected %h", wr_count, exp_v); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    idle();
    rd_addr_a = '0;
    rd_addr_b = '0;
    model_cnt = 16'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_flags();
    test_back_to_back();
    test_counter_wrap();

    if (model_cnt !== 16'h0000 || exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_end: model count %h (required 0000), %0d entries left (required 0)", model_cnt, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
